// File: rtl/cla_pkg.sv
// Shared types and constants for the cacheline adapter.
package cla_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEAT_CNT_W = 2;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrData,
        StResp
    } cla_state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// 256-bit cacheline to 4x64-bit bmem burst responder for the D-cache line port.
// Optional CLA_RADDR_CHECK_EN adds a sticky check of returning read-beat address tags.
module cacheline_adapter
    import cla_pkg::*;
#(
    parameter int unsigned BEAT_W    = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ufp_addr,
    input  logic              ufp_read,
    input  logic              ufp_write,
    input  logic [LINE_W-1:0] ufp_wdata,
    output logic [LINE_W-1:0] ufp_rdata,
    output logic              ufp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              raddr_err
);

    if (BEAT_W * BURST_LEN != LINE_W) begin : g_bad_geometry
        $error("cacheline_adapter: BEAT_W*BURST_LEN must equal LINE_W");
    end
    if (BURST_LEN != (1 << BEAT_CNT_W)) begin : g_bad_burst
        $error("cacheline_adapter: BURST_LEN must match the beat counter width");
    end

    localparam beat_cnt_t LastBeat = beat_cnt_t'(BURST_LEN - 1);

    cla_state_e        state_q;
    beat_cnt_t         cnt_q;
    beat_cnt_t         cnt_nxt;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] asm_line;
    logic [LINE_W-1:0] ufp_rdata_q;
    logic              ufp_resp_q;
    logic [31:0]       bmem_addr_q;
    logic              bmem_read_q;
    logic              bmem_write_q;
    logic [BEAT_W-1:0] bmem_wdata_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ufp_addr[4:0];

    assign cnt_nxt = cnt_q + beat_cnt_t'(1);

    // Line buffer with the incoming beat merged into its slot.
    always_comb begin
        asm_line = line_q;
        asm_line[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
    end

`ifdef CLA_RADDR_CHECK_EN
    logic raddr_err_q;
    assign raddr_err = raddr_err_q;
`else
    logic unused_raddr;
    assign unused_raddr = ^bmem_raddr;
    assign raddr_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            line_q       <= '0;
            ufp_rdata_q  <= '0;
            ufp_resp_q   <= 1'b0;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
`ifdef CLA_RADDR_CHECK_EN
            raddr_err_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ufp_write) begin
                        state_q      <= StWrData;
                        cnt_q        <= '0;
                        bmem_addr_q  <= {ufp_addr[31:5], 5'b0};
                        line_q       <= ufp_wdata;
                        bmem_wdata_q <= ufp_wdata[BEAT_W-1:0];
                        bmem_write_q <= 1'b1;
                    end else if (ufp_read) begin
                        state_q     <= StRdReq;
                        cnt_q       <= '0;
                        bmem_addr_q <= {ufp_addr[31:5], 5'b0};
                        bmem_read_q <= 1'b1;
                    end
                end
                StRdReq: begin
                    if (bmem_ready) begin
                        state_q     <= StRdData;
                        cnt_q       <= '0;
                        bmem_read_q <= 1'b0;
                    end
                end
                StRdData: begin
                    if (bmem_rvalid) begin
                        line_q <= asm_line;
`ifdef CLA_RADDR_CHECK_EN
                        if (bmem_raddr != bmem_addr_q) begin
                            raddr_err_q <= 1'b1;
                        end
`endif
                        if (cnt_q == LastBeat) begin
                            state_q     <= StResp;
                            cnt_q       <= '0;
                            ufp_rdata_q <= asm_line;
                            ufp_resp_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                StWrData: begin
                    if (bmem_ready) begin
                        if (cnt_q == LastBeat) begin
                            state_q      <= StResp;
                            cnt_q        <= '0;
                            bmem_write_q <= 1'b0;
                            ufp_resp_q   <= 1'b1;
                        end else begin
                            cnt_q        <= cnt_nxt;
                            bmem_wdata_q <= line_q[cnt_nxt*BEAT_W +: BEAT_W];
                        end
                    end
                end
                StResp: begin
                    // Request is still high here; IDLE resamples only next cycle.
                    state_q    <= StIdle;
                    ufp_resp_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ufp_rdata  = ufp_rdata_q;
    assign ufp_resp   = ufp_resp_q;
    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule
